// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine and its BCD conversion stage.
package gcd_pkg;

  localparam int GCD_WIDTH  = 16;
  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: values of 5 or more get +3 before the shift.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] corrected
);

  assign corrected = (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;

endmodule

// File: rtl/gcd_bcd_conv.sv
// Sequential binary-to-packed-BCD converter fed by the GCD engine result.
// Optional leading-zero blanking mask is built when GCD_BCD_BLANK_EN is defined.
module gcd_bcd_conv
  import gcd_pkg::*;
#(
  parameter int WIDTH  = GCD_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int SR_W  = 4*DIGITS + WIDTH;
  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  state_t               state;
  state_t               state_next;
  logic                 start_q;
  logic [SR_W-1:0]      sr;
  logic [SR_W-1:0]      sr_next;
  logic [SR_W-1:0]      sr_adj;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 busy_next;
  logic                 done_next;
  logic [4*DIGITS-1:0]  bcd_next;
  logic [DIGITS-1:0]    blank_next;
  logic                 trigger;

  assign trigger = start & ~start_q;

  // Add-3 correction of every BCD nibble ahead of the shift; binary part passes through.
  assign sr_adj[WIDTH-1:0] = sr[WIDTH-1:0];
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble    (sr[WIDTH+4*g +: 4]),
      .corrected (sr_adj[WIDTH+4*g +: 4])
    );
  end

`ifdef GCD_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_calc;
  logic              upper_zero;

  // Leading-zero mask from the finished digits; digit 0 is never blanked.
  always_comb begin
    blank_calc = {DIGITS{1'b0}};
    upper_zero = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      upper_zero    = upper_zero & (sr[WIDTH+4*i +: 4] == 4'd0);
      blank_calc[i] = upper_zero;
    end
  end
`endif

  // Next-state and next-output logic of the conversion FSM.
  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_next   = cnt;
    busy_next  = busy;
    done_next  = 1'b0;
    bcd_next   = bcd;
    blank_next = blank;
    case (state)
      IDLE: begin
        if (trigger) begin
          sr_next    = {{(4*DIGITS){1'b0}}, bin};
          cnt_next   = {CNT_W{1'b0}};
          busy_next  = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        sr_next  = {sr_adj[SR_W-2:0], 1'b0};
        cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt == CNT_W'(WIDTH-1)) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE: begin
        bcd_next   = sr[SR_W-1 -: 4*DIGITS];
`ifdef GCD_BCD_BLANK_EN
        blank_next = blank_calc;
`else
        blank_next = {DIGITS{1'b0}};
`endif
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any conversion silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      sr      <= {SR_W{1'b0}};
      cnt     <= {CNT_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= {(4*DIGITS){1'b0}};
      blank   <= {DIGITS{1'b0}};
    end else begin
      state   <= state_next;
      start_q <= start;
      sr      <= sr_next;
      cnt     <= cnt_next;
      busy    <= busy_next;
      done    <= done_next;
      bcd     <= bcd_next;
      blank   <= blank_next;
    end
  end

endmodule
